cond_eval: RTL and testbench

- Flag consumer paired with the subtract-based comparator.
- Latches the comparator's V/N/Z/C flags into a flag register.
- Accepts condition-code requests over a valid/ready handshake and returns a registered taken/not-taken decision.
- Sits between the comparator and the branch/select logic of the datapath.

---
 rtl/cond_pkg.sv | 43 ++++
 rtl/cond_check.sv | 38 +++
 rtl/cond_eval.sv | 132 +++++++++++++
 tb/tb_cond_eval.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cond_pkg.sv
// Shared types for the condition evaluator and the branch unit.
// Holds the condition-code enum, the {V,N,Z,C} flag struct and the
// evaluator FSM state encoding.
package cond_pkg;

   localparam int unsigned COND_W  = 4;
   localparam int unsigned FLAGS_W = 4;

   // Condition codes, 4-bit encoding shared with the instruction decoder
   typedef enum logic [COND_W-1:0] {
      COND_EQ = 4'd0,
      COND_NE = 4'd1,
      COND_HS = 4'd2,
      COND_LO = 4'd3,
      COND_MI = 4'd4,
      COND_PL = 4'd5,
      COND_VS = 4'd6,
      COND_VC = 4'd7,
      COND_HI = 4'd8,
      COND_LS = 4'd9,
      COND_GE = 4'd10,
      COND_LT = 4'd11,
      COND_GT = 4'd12,
      COND_LE = 4'd13,
      COND_AL = 4'd14,
      COND_NV = 4'd15
   } cond_e;

   // Comparator flags; packing order matches the flags_q port {V,N,Z,C}
   typedef struct packed {
      logic v;
      logic n;
      logic z;
      logic c;
   } flags_t;

   typedef enum logic [1:0] {
      NOFLAGS = 2'd0,
      IDLE    = 2'd1,
      BUSY    = 2'd2
   } state_e;

endpackage : cond_pkg

// File: rtl/cond_check.sv
// Combinational condition-code check against a set of comparator flags.
// Ports:
//   flags  in  flags_t  {v,n,z,c} from a subtract-based compare
//   cond   in  cond_e   condition code to test
//   taken  out 1        1 when the condition holds
module cond_check
   import cond_pkg::*;
(
   input  flags_t flags,
   input  cond_e  cond,
   output logic   taken
);

   // Signed relations derive from N==V (true sign of the difference)
   always_comb begin
      taken = 1'b0;
      case (cond)
         COND_EQ: taken = flags.z;
         COND_NE: taken = ~flags.z;
         COND_HS: taken = flags.c;
         COND_LO: taken = ~flags.c;
         COND_MI: taken = flags.n;
         COND_PL: taken = ~flags.n;
         COND_VS: taken = flags.v;
         COND_VC: taken = ~flags.v;
         COND_HI: taken = flags.c & ~flags.z;
         COND_LS: taken = ~flags.c | flags.z;
         COND_GE: taken = (flags.n == flags.v);
         COND_LT: taken = (flags.n != flags.v);
         COND_GT: taken = ~flags.z & (flags.n == flags.v);
         COND_LE: taken = flags.z | (flags.n != flags.v);
         COND_AL: taken = 1'b1;
         COND_NV: taken = 1'b0;
         default: taken = 1'b0;
      endcase
   end

endmodule : cond_check

// File: rtl/cond_eval.sv
// Condition evaluator: latches comparator flags and answers condition-code
// requests with a registered taken/not-taken decision one cycle later.
// Optional macro COND_STATS_EN adds saturating taken/not-taken counters.
// Parameters:
//   BYPASS  1: a request accepted together with flag_valid uses the incoming
//              flags; 0: it uses the flag register
//   CNT_W   statistics counter width
// Ports:
//   clk, rst                       clock, async active-high reset
//   flag_valid, flag_v/n/z/c       comparator result and its flags
//   req_valid, req_cond, req_ready condition request handshake
//   resp_valid, resp_taken,
//   resp_cond, resp_ready          decision handshake
//   flags_q                        flag register {V,N,Z,C}
//   cnt_taken, cnt_not             statistics (zero without COND_STATS_EN)
module cond_eval
   import cond_pkg::*;
#(
   parameter int unsigned BYPASS = 1,
   parameter int unsigned CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flag_valid,
   input  logic             flag_v,
   input  logic             flag_n,
   input  logic             flag_z,
   input  logic             flag_c,
   input  logic             req_valid,
   input  logic [3:0]       req_cond,
   output logic             req_ready,
   output logic             resp_valid,
   output logic             resp_taken,
   output logic [3:0]       resp_cond,
   input  logic             resp_ready,
   output logic [3:0]       flags_q,
   output logic [CNT_W-1:0] cnt_taken,
   output logic [CNT_W-1:0] cnt_not
);

   state_e state;
   flags_t flags_r;
   flags_t flags_in;
   flags_t eval_flags;
   logic   accept;
   logic   taken;

   assign flags_in = {flag_v, flag_n, flag_z, flag_c};
   assign flags_q  = flags_r;

   // A pending response frees the slot only if it is drained this cycle
   assign req_ready = (state != NOFLAGS) && (!resp_valid || resp_ready);
   assign accept    = req_valid && req_ready;

   assign eval_flags = ((BYPASS != 0) && flag_valid) ? flags_in : flags_r;

   cond_check u_check (
      .flags (eval_flags),
      .cond  (cond_e'(req_cond)),
      .taken (taken)
   );

   // Control FSM with flag register and response registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= NOFLAGS;
         flags_r    <= '0;
         resp_valid <= 1'b0;
         resp_taken <= 1'b0;
         resp_cond  <= '0;
      end else begin
         if (flag_valid) begin
            flags_r <= flags_in;
         end
         case (state)
            NOFLAGS: begin
               if (flag_valid) begin
                  state <= IDLE;
               end
            end
            IDLE: begin
               if (accept) begin
                  state      <= BUSY;
                  resp_valid <= 1'b1;
                  resp_taken <= taken;
                  resp_cond  <= req_cond;
               end
            end
            BUSY: begin
               // accept implies resp_ready here, so the old response drains
               if (accept) begin
                  resp_taken <= taken;
                  resp_cond  <= req_cond;
               end else if (resp_ready) begin
                  state      <= IDLE;
                  resp_valid <= 1'b0;
               end
            end
            default: begin
               state      <= NOFLAGS;
               resp_valid <= 1'b0;
            end
         endcase
      end
   end

`ifdef COND_STATS_EN
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   // Saturating statistics, counted at acceptance
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_taken <= '0;
         cnt_not   <= '0;
      end else if (accept) begin
         if (taken) begin
            if (cnt_taken != CNT_MAX) begin
               cnt_taken <= cnt_taken + CNT_W'(1);
            end
         end else begin
            if (cnt_not != CNT_MAX) begin
               cnt_not <= cnt_not + CNT_W'(1);
            end
         end
      end
   end
`else
   assign cnt_taken = '0;
   assign cnt_not   = '0;
`endif

endmodule : cond_eval

// File: tb/tb_cond_eval.sv
// Bench for cond_eval. Flags are generated from 32-bit operand pairs; the
// model evaluates conditions as direct signed/unsigned relations on those
// operands and tracks the request/response handshake as a single slot.
module tb_cond_eval;

   localparam int unsigned TB_BYPASS = 1;
   localparam int unsigned TB_CNT_W  = 2;
   localparam int          CMAX      = (1 << TB_CNT_W) - 1;

   localparam logic [3:0] C_EQ = 4'd0,  C_NE = 4'd1,  C_HS = 4'd2,  C_LO = 4'd3;
   localparam logic [3:0] C_MI = 4'd4,  C_PL = 4'd5,  C_VS = 4'd6,  C_VC = 4'd7;
   localparam logic [3:0] C_HI = 4'd8,  C_LS = 4'd9,  C_GE = 4'd10, C_LT = 4'd11;
   localparam logic [3:0] C_GT = 4'd12, C_LE = 4'd13, C_AL = 4'd14, C_NV = 4'd15;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                flag_valid = 1'b0;
   logic                flag_v = 1'b0, flag_n = 1'b0, flag_z = 1'b0, flag_c = 1'b0;
   logic                req_valid = 1'b0;
   logic [3:0]          req_cond = 4'd0;
   logic                req_ready;
   logic                resp_valid;
   logic                resp_taken;
   logic [3:0]          resp_cond;
   logic                resp_ready = 1'b0;
   logic [3:0]          flags_q;
   logic [TB_CNT_W-1:0] cnt_taken;
   logic [TB_CNT_W-1:0] cnt_not;

   logic [31:0] in_x = '0, in_y = '0;

   int n_checks = 0;
   int n_pass   = 0;

   // model state
   logic        m_have  = 1'b0;
   logic        m_busy  = 1'b0;
   logic        m_taken = 1'b0;
   logic [3:0]  m_cond  = '0;
   logic [31:0] m_fa = '0, m_fb = '0;
   int          m_cnt_t = 0, m_cnt_n = 0;

   cond_eval #(.BYPASS(TB_BYPASS), .CNT_W(TB_CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .flag_valid (flag_valid),
      .flag_v     (flag_v),
      .flag_n     (flag_n),
      .flag_z     (flag_z),
      .flag_c     (flag_c),
      .req_valid  (req_valid),
      .req_cond   (req_cond),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_taken (resp_taken),
      .resp_cond  (resp_cond),
      .resp_ready (resp_ready),
      .flags_q    (flags_q),
      .cnt_taken  (cnt_taken),
      .cnt_not    (cnt_not)
   );

   always #5 clk = ~clk;

   // Flags a subtractor produces for a - b: {V,N,Z,C}
   function automatic logic [3:0] flags_of(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] s;
      logic        v;
      s = {1'b0, a} + {1'b0, ~b} + 33'd1;
      v = (a[31] != b[31]) && (s[31] != a[31]);
      return {v, s[31], (s[31:0] == 32'd0), s[32]};
   endfunction

   // Condition expressed as the relation between the compared operands
   function automatic logic cond_holds(input logic [3:0] c, input logic [31:0] a,
                                       input logic [31:0] b);
      longint sd;
      logic   ovf;
      logic [31:0] d;
      sd  = longint'($signed(a)) - longint'($signed(b));
      ovf = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
      d   = a - b;
      case (c)
         C_EQ: return a == b;
         C_NE: return a != b;
         C_HS: return a >= b;
         C_LO: return a < b;
         C_MI: return d[31];
         C_PL: return !d[31];
         C_VS: return ovf;
         C_VC: return !ovf;
         C_HI: return a > b;
         C_LS: return a <= b;
         C_GE: return $signed(a) >= $signed(b);
         C_LT: return $signed(a) < $signed(b);
         C_GT: return $signed(a) > $signed(b);
         C_LE: return $signed(a) <= $signed(b);
         C_AL: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // One cycle of stimulus; returns 1 time unit after the active edge
   task automatic drive(input logic fv, input logic [31:0] x, input logic [31:0] y,
                        input logic rv, input logic [3:0] c, input logic rr);
      flag_valid = fv;
      in_x = x;
      in_y = y;
      {flag_v, flag_n, flag_z, flag_c} = flags_of(x, y);
      req_valid  = rv;
      req_cond   = c;
      resp_ready = rr;
      @(posedge clk);
      #1;
   endtask

   // Model: one response slot, operands of the most recent flag capture
   always @(posedge clk or posedge rst) begin : model
      logic        rdy, acc, t;
      logic [31:0] ea, eb;
      if (rst) begin
         m_have  <= 1'b0;
         m_busy  <= 1'b0;
         m_taken <= 1'b0;
         m_cond  <= '0;
         m_cnt_t <= 0;
         m_cnt_n <= 0;
      end else begin
         rdy = m_have && (!m_busy || resp_ready);
         acc = req_valid && rdy;
         ea  = (TB_BYPASS != 0 && flag_valid) ? in_x : m_fa;
         eb  = (TB_BYPASS != 0 && flag_valid) ? in_y : m_fb;
         t   = cond_holds(req_cond, ea, eb);
         if (acc) begin
            m_busy  <= 1'b1;
            m_taken <= t;
            m_cond  <= req_cond;
            if (t) m_cnt_t <= (m_cnt_t < CMAX) ? m_cnt_t + 1 : m_cnt_t;
            else   m_cnt_n <= (m_cnt_n < CMAX) ? m_cnt_n + 1 : m_cnt_n;
         end else if (m_busy && resp_ready) begin
            m_busy <= 1'b0;
         end
         if (flag_valid) begin
            m_have <= 1'b1;
            m_fa   <= in_x;
            m_fb   <= in_y;
         end
      end
   end

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      chk("req_ready", 32'(req_ready), 32'(m_have && (!m_busy || resp_ready)));
      chk("resp_valid", 32'(resp_valid), 32'(m_busy));
      chk("flags_q", 32'(flags_q), m_have ? 32'(flags_of(m_fa, m_fb)) : 32'd0);
      if (m_busy) begin
         chk("resp_taken", 32'(resp_taken), 32'(m_taken));
         chk("resp_cond", 32'(resp_cond), 32'(m_cond));
      end
`ifdef COND_STATS_EN
      chk("cnt_taken", 32'(cnt_taken), 32'(m_cnt_t));
      chk("cnt_not", 32'(cnt_not), 32'(m_cnt_n));
`else
      chk("cnt_taken", 32'(cnt_taken), 32'd0);
      chk("cnt_not", 32'(cnt_not), 32'd0);
`endif
   end

   initial begin : stim
      logic [31:0] pa [6];
      logic [31:0] pb [6];
      pa = '{32'd5, 32'd7, 32'd7, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF};
      pb = '{32'd7, 32'd5, 32'd7, 32'd1, 32'h8000_0000, 32'hFFFF_FFFF};

      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_flags_q", 32'(flags_q), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);

      // requests before any flags are never accepted
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 32'd0, 32'd0, 1'b1, C_EQ, 1'b1);
         chk("noflags_ready", 32'(req_ready), 32'd0);
         chk("noflags_valid", 32'(resp_valid), 32'd0);
      end

      // X=5, Y=7; flag_valid in NOFLAGS does not accept the request
      drive(1'b1, 32'd5, 32'd7, 1'b1, C_LT, 1'b1);
      chk("flags_5_7", 32'(flags_q), 32'h4);
      chk("no_accept_noflags", 32'(resp_valid), 32'd0);
      drive(1'b0, 32'd0, 32'd0, 1'b1, C_LT, 1'b1);
      chk("lt_taken", 32'(resp_taken), 32'd1);
      chk("lt_cond", 32'(resp_cond), 32'(C_LT));
      drive(1'b0, 32'd0, 32'd0, 1'b1, C_LO, 1'b1);
      chk("lo_taken", 32'(resp_taken), 32'd1);
      drive(1'b0, 32'd0, 32'd0, 1'b1, C_GE, 1'b1);
      chk("ge_taken", 32'(resp_taken), 32'd0);
      chk("ge_valid", 32'(resp_valid), 32'd1);
      drive(1'b0, 32'd0, 32'd0, 1'b0, C_GE, 1'b1);
      chk("drain1", 32'(resp_valid), 32'd0);

      // X=7, Y=7; stalled EQ response held while flags change underneath
      drive(1'b1, 32'd7, 32'd7, 1'b0, C_EQ, 1'b1);
      chk("flags_7_7", 32'(flags_q), 32'h3);
      drive(1'b0, 32'd0, 32'd0, 1'b1, C_EQ, 1'b0);
      for (int i = 0; i < 3; i++) begin
         drive(i == 1, 32'd5, 32'd7, 1'b1, C_EQ, 1'b0);
         chk("stall_valid", 32'(resp_valid), 32'd1);
         chk("stall_taken", 32'(resp_taken), 32'd1);
         chk("stall_ready", 32'(req_ready), 32'd0);
      end
      drive(1'b0, 32'd0, 32'd0, 1'b0, C_EQ, 1'b1);
      chk("drain2", 32'(resp_valid), 32'd0);

      // signed overflow case
      drive(1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, C_GE, 1'b1);
      chk("flags_ovf", 32'(flags_q), 32'hC);
      drive(1'b0, 32'd0, 32'd0, 1'b1, C_GE, 1'b1);
      chk("ovf_ge", 32'(resp_taken), 32'd1);
      drive(1'b0, 32'd0, 32'd0, 1'b1, C_MI, 1'b1);
      chk("ovf_mi", 32'(resp_taken), 32'd1);
      drive(1'b0, 32'd0, 32'd0, 1'b1, C_VS, 1'b1);
      chk("ovf_vs", 32'(resp_taken), 32'd1);
      drive(1'b0, 32'd0, 32'd0, 1'b0, C_VS, 1'b1);

      // bypass: Z=0 held, Z=1 arriving with the EQ request
      drive(1'b1, 32'd7, 32'd7, 1'b1, C_EQ, 1'b1);
      chk("bypass_eq", 32'(resp_taken), (TB_BYPASS != 0) ? 32'd1 : 32'd0);
      drive(1'b0, 32'd0, 32'd0, 1'b0, C_EQ, 1'b1);

      // counter saturation
      for (int i = 0; i < 5; i++) drive(1'b0, 32'd0, 32'd0, 1'b1, C_AL, 1'b1);
      for (int i = 0; i < 2; i++) drive(1'b0, 32'd0, 32'd0, 1'b1, C_NV, 1'b1);
      drive(1'b0, 32'd0, 32'd0, 1'b0, C_NV, 1'b1);
`ifdef COND_STATS_EN
      chk("cnt_taken_sat", 32'(cnt_taken), 32'd3);
      chk("cnt_not_sat", 32'(cnt_not), 32'd3);
`endif

      // asynchronous reset while a response is pending
      drive(1'b0, 32'd0, 32'd0, 1'b1, C_AL, 1'b0);
      chk("busy_before_rst", 32'(resp_valid), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_valid", 32'(resp_valid), 32'd0);
      chk("async_rst_ready", 32'(req_ready), 32'd0);
      chk("async_rst_flags", 32'(flags_q), 32'd0);
      chk("async_rst_cnt", 32'({cnt_taken, cnt_not}), 32'd0);
      req_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;

      // sweep every condition over several operand pairs, with stalls
      for (int p = 0; p < 6; p++) begin
         drive(1'b1, pa[p], pb[p], 1'b0, C_EQ, 1'b1);
         for (int c = 0; c < 16; c++)
            drive(1'b0, 32'd0, 32'd0, 1'b1, 4'(c), (c % 5) != 3);
         drive(1'b0, 32'd0, 32'd0, 1'b0, C_EQ, 1'b1);
      end

      // bypass combined with a drained response in BUSY
      drive(1'b1, 32'd3, 32'd9, 1'b1, C_LO, 1'b1);
      drive(1'b1, 32'd9, 32'd3, 1'b1, C_HI, 1'b1);
      drive(1'b0, 32'd0, 32'd0, 1'b0, C_EQ, 1'b1);
      drive(1'b0, 32'd0, 32'd0, 1'b0, C_EQ, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_cond_eval
